// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the halfword-memory access unit.
//   size_e  : request access size encoding
//   state_e : sequencer states
//   is_aligned : natural-alignment check for a byte address and size
package mem_access_pkg;

    localparam int unsigned HALF_W = 16;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD0,
        ST_RD1,
        ST_RDC,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_WR0,
        ST_WR1,
        ST_RESP,
        ST_ERR
    } state_e;

    // Bytes are always aligned; the reserved size is never legal.
    function automatic logic is_aligned(input size_e sz, input logic [1:0] a_lo);
        logic ok;
        case (sz)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~a_lo[0];
            SZ_WORD: ok = (a_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Combinational byte-lane helper.
//   rd_half      : halfword returned by the memory
//   lane         : byte lane (0 = [7:0], 1 = [15:8])
//   size         : access size (size_e encoding)
//   sgn          : sign-extend byte/half load data
//   wbyte        : store byte for read-modify-write
//   load_data_c  : extended byte/half load data
//   merge_data_c : rd_half with wbyte placed into the selected lane
module mem_byte_lane
    import mem_access_pkg::*;
(
    input  logic [15:0] rd_half,
    input  logic        lane,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [7:0]  wbyte,
    output logic [31:0] load_data_c,
    output logic [15:0] merge_data_c
);

    logic [7:0] byte_sel;

    always_comb begin
        byte_sel     = lane ? rd_half[15:8] : rd_half[7:0];
        load_data_c  = {16'h0000, rd_half};
        merge_data_c = lane ? {wbyte, rd_half[7:0]} : {rd_half[15:8], wbyte};
        case (size)
            SZ_BYTE: load_data_c = {{24{sgn & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data_c = {{16{sgn & rd_half[15]}}, rd_half};
            default: load_data_c = {16'h0000, rd_half};
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Request front end for a single-port 16-bit halfword memory. Turns byte
// addressed byte/half/word loads and stores into halfword memory cycles and
// returns one registered response per request.
//   clk, rst_n         : clock, synchronous active-low reset
//   req_*              : request channel (req_ready high only when idle)
//   rsp_valid/err/rdata: one-cycle response pulse
//   mem_*              : memory pins (mem_dout valid the cycle after a read)
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter  int unsigned MEM_DEPTH   = 4096,
    localparam int unsigned ADDR_WIDTH  = $clog2(MEM_DEPTH),
    localparam int unsigned BADDR_WIDTH = ADDR_WIDTH + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [1:0]             req_size,
    input  logic                   req_signed,
    input  logic [BADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]            req_wdata,
    output logic                   rsp_valid,
    output logic                   rsp_err,
    output logic [31:0]            rsp_rdata,
    output logic                   mem_en,
    output logic                   mem_rd_en,
    output logic                   mem_wr_en,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [15:0]            mem_din,
    input  logic [15:0]            mem_dout
);

    state_e state, next_state;

    // Latched request
    logic                   we_q;
    size_e                  size_q;
    logic                   sgn_q;
    logic [BADDR_WIDTH-1:0] addr_q;
    logic [31:0]            wdata_q;
    logic [15:0]            lo_q;
    logic [15:0]            din_q;

    // Next values of registered outputs
    logic                   req_ready_d;
    logic                   rsp_valid_d;
    logic                   rsp_err_d;
    logic [31:0]            rsp_rdata_d;
    logic                   mem_en_d;
    logic                   mem_rd_en_d;
    logic                   mem_wr_en_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_d;
    logic [15:0]            din_d;
    logic [15:0]            lo_d;

    logic                   accept;
    size_e                  size_in;
    logic [ADDR_WIDTH-1:0]  h_in;
    logic [ADDR_WIDTH-1:0]  h_q;
    logic [31:0]            load_c;
    logic [15:0]            merge_c;

    assign accept  = req_valid & req_ready;
    assign size_in = size_e'(req_size);
    assign h_in    = req_addr[BADDR_WIDTH-1:1];
    assign h_q     = addr_q[BADDR_WIDTH-1:1];

    mem_byte_lane u_lane (
        .rd_half      (mem_dout),
        .lane         (addr_q[0]),
        .size         (size_q),
        .sgn          (sgn_q),
        .wbyte        (wdata_q[7:0]),
        .load_data_c  (load_c),
        .merge_data_c (merge_c)
    );

    // The RMW write data depends on the read returned in the same cycle,
    // so it bypasses the write-data register.
    assign mem_din = (state == ST_RMW_WR) ? merge_c : din_q;

    // Next-state and next-output decode
    always_comb begin
        next_state  = state;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        mem_en_d    = 1'b0;
        mem_rd_en_d = 1'b0;
        mem_wr_en_d = 1'b0;
        mem_addr_d  = mem_addr;
        din_d       = '0;
        lo_d        = lo_q;

        case (state)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (accept) begin
                    req_ready_d = 1'b0;
                    if (!is_aligned(size_in, req_addr[1:0])) begin
                        next_state  = ST_ERR;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (!req_we) begin
                        next_state  = ST_RD0;
                        mem_en_d    = 1'b1;
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = h_in;
                    end else if (size_in == SZ_BYTE) begin
                        next_state  = ST_RMW_RD;
                        mem_en_d    = 1'b1;
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = h_in;
                    end else begin
                        next_state  = ST_WR0;
                        mem_en_d    = 1'b1;
                        mem_wr_en_d = 1'b1;
                        mem_addr_d  = h_in;
                        din_d       = req_wdata[15:0];
                    end
                end
            end

            ST_RD0: begin
                if (size_q == SZ_WORD) begin
                    next_state  = ST_RD1;
                    mem_en_d    = 1'b1;
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = h_q + ADDR_WIDTH'(1);
                end else begin
                    next_state = ST_RDC;
                end
            end

            ST_RD1: begin
                lo_d       = mem_dout;
                next_state = ST_RDC;
            end

            ST_RDC: begin
                next_state  = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = (size_q == SZ_WORD) ? {mem_dout, lo_q} : load_c;
            end

            ST_RMW_RD: begin
                next_state  = ST_RMW_WR;
                mem_en_d    = 1'b1;
                mem_wr_en_d = 1'b1;
                mem_addr_d  = h_q;
            end

            ST_RMW_WR: begin
                next_state  = ST_RESP;
                rsp_valid_d = 1'b1;
            end

            ST_WR0: begin
                if (size_q == SZ_WORD) begin
                    next_state  = ST_WR1;
                    mem_en_d    = 1'b1;
                    mem_wr_en_d = 1'b1;
                    mem_addr_d  = h_q + ADDR_WIDTH'(1);
                    din_d       = wdata_q[31:16];
                end else begin
                    next_state  = ST_RESP;
                    rsp_valid_d = 1'b1;
                end
            end

            ST_WR1: begin
                next_state  = ST_RESP;
                rsp_valid_d = 1'b1;
            end

            ST_RESP, ST_ERR: begin
                next_state  = ST_IDLE;
                req_ready_d = 1'b1;
            end

            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State, output and request registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            mem_en    <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_addr  <= '0;
            din_q     <= '0;
            lo_q      <= '0;
            we_q      <= 1'b0;
            size_q    <= SZ_BYTE;
            sgn_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state     <= next_state;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
            mem_en    <= mem_en_d;
            mem_rd_en <= mem_rd_en_d;
            mem_wr_en <= mem_wr_en_d;
            mem_addr  <= mem_addr_d;
            din_q     <= din_d;
            lo_q      <= lo_d;
            if (accept) begin
                we_q    <= req_we;
                size_q  <= size_in;
                sgn_q   <= req_signed;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    logic unused_we;
    assign unused_we = we_q;

endmodule
